// File: rtl/dtcm_store_buffer_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// dtcm_store_buffer_pkg : store-size codes, byte-enable patterns, entry widths
// rev 1.0
// ------------------------------------------------------------------------
package dtcm_store_buffer_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } st_size_e;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  localparam int SB_BE_BITS   = 4;
  localparam int SB_DATA_BITS = 32;

  // Entry layout, MSB first: {word_addr, be, data}
  function automatic int sb_entry_w(input int wa_w);
    return wa_w + SB_BE_BITS + SB_DATA_BITS;
  endfunction

endpackage : dtcm_store_buffer_pkg
`default_nettype wire

// File: rtl/dtcm_store_buffer_fifo.sv
`default_nettype none
// ------------------------------------------------------------------------
// dtcm_sb_fifo : circular store-buffer FIFO with per-entry hazard taps
// rev 1.0
// ------------------------------------------------------------------------
module dtcm_sb_fifo #(
  parameter int DEPTH = 4,
  parameter int WA_W  = 10,
  parameter int EW    = 46
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_push,
  input  logic [EW-1:0]               i_entry,
  input  logic                        i_pop,
  output logic [EW-1:0]               o_head,
  output logic [$clog2(DEPTH+1)-1:0]  o_count,
  output logic                        o_empty,
  output logic [DEPTH*(WA_W+1)-1:0]   o_hz_vec
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [EW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && (r_count != CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload needs no reset; occupancy is carried by the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

  for (genvar i = 0; i < DEPTH; i++) begin : g_hz
    logic [PTR_W-1:0] w_off;
    assign w_off = PTR_W'(i) - r_rd_ptr;
    assign o_hz_vec[i*(WA_W+1) +: (WA_W+1)] =
      {(CNT_W'(w_off) < r_count), r_mem[i][EW-1 -: WA_W]};
  end

endmodule : dtcm_sb_fifo
`default_nettype wire

// File: rtl/dtcm_store_buffer.sv
`default_nettype none
// ------------------------------------------------------------------------
// dtcm_store_buffer : byte-addressed data TCM fed through a store buffer
// rev 1.0
// ------------------------------------------------------------------------
module dtcm_store_buffer
  import dtcm_store_buffer_pkg::*;
#(
  parameter int AW       = 12,
  parameter int SB_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_st_valid,
  output logic                           o_st_ready,
  input  logic [AW-1:0]                  i_st_addr,
  input  logic [31:0]                    i_st_data,
  input  logic [1:0]                     i_st_size,
  input  logic                           i_hst_en,
  input  logic [AW-1:0]                  i_hst_addr,
  input  logic [7:0]                     i_hst_data,
  input  logic [AW-1:0]                  i_ld_addr,
  output logic [31:0]                    o_ld_data,
  output logic                           o_ld_hazard,
  output logic                           o_sb_empty,
  output logic [$clog2(SB_DEPTH+1)-1:0]  o_sb_count,
  output logic                           o_misalign_err
);

  localparam int WA_W  = AW - 2;
  localparam int EW    = sb_entry_w(WA_W);
  localparam int CNT_W = $clog2(SB_DEPTH+1);

  logic [7:0]                   r_mem [0:(1<<AW)-1];
  logic                         r_misalign;
  logic [3:0]                   w_be_base;
  logic [3:0]                   w_be;
  logic [31:0]                  w_data;
  logic                         w_illegal;
  logic                         w_accept;
  logic                         w_push;
  logic                         w_pop;
  logic [EW-1:0]                w_head;
  logic [WA_W-1:0]              w_head_wa;
  logic [3:0]                   w_head_be;
  logic [31:0]                  w_head_data;
  logic [SB_DEPTH*(WA_W+1)-1:0] w_hz_vec;
  logic [AW-1:0]                w_ld_a [4];
  logic [WA_W-1:0]              w_lo_wa;
  logic [WA_W-1:0]              w_hi_wa;

  // Ready looks only at registered occupancy; a same-cycle drain does not help.
  assign o_st_ready = (o_sb_count < CNT_W'(SB_DEPTH));
  assign w_accept   = i_st_valid && o_st_ready;
  assign w_push     = w_accept && !w_illegal;
  assign w_pop      = !o_sb_empty && !i_hst_en;

  always_comb begin
    w_be_base = '0;
    w_illegal = 1'b0;
    case (i_st_size)
      SZ_B: w_be_base = BE_B;
      SZ_H: begin
        w_be_base = BE_H;
        w_illegal = i_st_addr[0];
      end
      SZ_W: begin
        w_be_base = BE_W;
        w_illegal = |i_st_addr[1:0];
      end
      default: w_illegal = 1'b1;
    endcase
    w_be   = w_be_base << i_st_addr[1:0];
    w_data = i_st_data << {i_st_addr[1:0], 3'b000};
  end

  dtcm_sb_fifo #(
    .DEPTH (SB_DEPTH),
    .WA_W  (WA_W),
    .EW    (EW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (w_push),
    .i_entry  ({i_st_addr[AW-1:2], w_be, w_data}),
    .i_pop    (w_pop),
    .o_head   (w_head),
    .o_count  (o_sb_count),
    .o_empty  (o_sb_empty),
    .o_hz_vec (w_hz_vec)
  );

  assign w_head_wa   = w_head[EW-1 -: WA_W];
  assign w_head_be   = w_head[35:32];
  assign w_head_data = w_head[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_misalign <= 1'b0;
    else        r_misalign <= w_accept && w_illegal;
  end
  assign o_misalign_err = r_misalign;

  // Host byte wins the write port; the drain simply waits.
  always_ff @(posedge clk) begin
    if (i_hst_en) begin
      r_mem[i_hst_addr] <= i_hst_data;
    end else if (w_pop) begin
      for (int l = 0; l < 4; l++) begin
        if (w_head_be[l]) r_mem[{w_head_wa, 2'(l)}] <= w_head_data[8*l +: 8];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_ld_a[k]          = i_ld_addr + AW'(k);
      o_ld_data[8*k +: 8] = r_mem[w_ld_a[k]];
    end
  end

  assign w_lo_wa = i_ld_addr[AW-1:2];
  assign w_hi_wa = w_ld_a[3][AW-1:2];

  always_comb begin
    o_ld_hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (w_hz_vec[i*(WA_W+1) + WA_W] &&
          ((w_hz_vec[i*(WA_W+1) +: WA_W] == w_lo_wa) ||
           (w_hz_vec[i*(WA_W+1) +: WA_W] == w_hi_wa)))
        o_ld_hazard = 1'b1;
    end
  end

endmodule : dtcm_store_buffer
`default_nettype wire

// File: tb/tb_dtcm_store_buffer.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_dtcm_store_buffer : directed stimulus checked against a byte-level model
// rev 1.0
// ------------------------------------------------------------------------
module tb_dtcm_store_buffer;

  localparam int MSZ = 4096;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        st_valid = 1'b0;
  logic [11:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [1:0]  st_size = '0;
  logic        hst_en = 1'b0;
  logic [11:0] hst_addr = '0;
  logic [7:0]  hst_data = '0;
  logic [11:0] ld_addr = '0;
  logic        o_st_ready;
  logic [31:0] o_ld_data;
  logic        o_ld_hazard;
  logic        o_sb_empty;
  logic [2:0]  o_sb_count;
  logic        o_misalign_err;

  int n_checks = 0;
  int n_pass   = 0;

  dtcm_store_buffer #(.AW(12), .SB_DEPTH(DEP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_st_valid     (st_valid),
    .o_st_ready     (o_st_ready),
    .i_st_addr      (st_addr),
    .i_st_data      (st_data),
    .i_st_size      (st_size),
    .i_hst_en       (hst_en),
    .i_hst_addr     (hst_addr),
    .i_hst_data     (hst_data),
    .i_ld_addr      (ld_addr),
    .o_ld_data      (o_ld_data),
    .o_ld_hazard    (o_ld_hazard),
    .o_sb_empty     (o_sb_empty),
    .o_sb_count     (o_sb_count),
    .o_misalign_err (o_misalign_err)
  );

  always #5 clk = ~clk;

  // Model: a queue of pending stores (byte address, size, raw data) and a byte memory.
  typedef struct {
    int          addr;
    int          size;
    logic [31:0] data;
  } st_t;

  st_t        q[$];
  logic [7:0] m_mem [MSZ];
  bit         m_known [MSZ];
  bit         m_merr = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_merr = 1'b0;
    end else begin
      int  n;
      bit  acc, ill;
      n   = q.size();
      acc = st_valid && (n < DEP);
      ill = (st_size == 2'd3) || (st_size == 2'd1 && st_addr[0]) ||
            (st_size == 2'd2 && st_addr[1:0] != 2'd0);
      if (hst_en) begin
        m_mem[hst_addr]   = hst_data;
        m_known[hst_addr] = 1'b1;
      end else if (n > 0) begin
        st_t e;
        int  nb;
        e  = q.pop_front();
        nb = (e.size == 0) ? 1 : (e.size == 1) ? 2 : 4;
        for (int i = 0; i < nb; i++) begin
          m_mem[(e.addr + i) % MSZ]   = e.data[8*i +: 8];
          m_known[(e.addr + i) % MSZ] = 1'b1;
        end
      end
      if (acc && !ill) q.push_back('{int'(st_addr), int'(st_size), st_data});
      m_merr = acc && ill;
    end
  end

  function automatic bit m_hazard(input logic [11:0] la);
    int w0 = int'(la) / 4;
    int w1 = ((int'(la) + 3) % MSZ) / 4;
    foreach (q[i]) if ((q[i].addr / 4) == w0 || (q[i].addr / 4) == w1) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    bit all_known;
    logic [31:0] exp_ld;
    chk("m_sb_count", 32'(o_sb_count), 32'(q.size()));
    chk("m_sb_empty", 32'(o_sb_empty), 32'(q.size() == 0));
    chk("m_st_ready", 32'(o_st_ready), 32'(q.size() < DEP));
    chk("m_misalign", 32'(o_misalign_err), 32'(m_merr));
    chk("m_ld_hazard", 32'(o_ld_hazard), 32'(m_hazard(ld_addr)));
    all_known = 1'b1;
    for (int k = 0; k < 4; k++) begin
      all_known &= m_known[(int'(ld_addr) + k) % MSZ];
      exp_ld[8*k +: 8] = m_mem[(int'(ld_addr) + k) % MSZ];
    end
    if (all_known) chk("m_ld_data", o_ld_data, exp_ld);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] t3_data [5];

  initial begin
    t3_data = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'hC0DE_0004};
    for (int i = 0; i < MSZ; i++) m_known[i] = 1'b0;

    // 1: reset with a store presented, then a single SW
    st_valid = 1'b1; st_size = 2'd2; st_addr = 12'h010; st_data = 32'hAABB_CCDD;
    #2 rst_n = 1'b0;
    step(); step();
    chk("rst_count", 32'(o_sb_count), 32'd0);
    chk("rst_empty", 32'(o_sb_empty), 32'd1);
    chk("rst_ready", 32'(o_st_ready), 32'd1);
    chk("rst_merr", 32'(o_misalign_err), 32'd0);
    rst_n = 1'b1;
    ld_addr = 12'h010;
    step();
    st_valid = 1'b0;
    chk("t1_count1", 32'(o_sb_count), 32'd1);
    step();
    chk("t1_count0", 32'(o_sb_count), 32'd0);
    chk("t1_ld", o_ld_data, 32'hAABB_CCDD);

    // 2: SB then SH merged into word 0x010, hazard while buffered
    hst_en = 1'b1; hst_addr = 12'h800; hst_data = 8'h5A;
    st_valid = 1'b1; st_size = 2'd0; st_addr = 12'h013; st_data = 32'h0000_0011;
    step();
    st_size = 2'd1; st_addr = 12'h010; st_data = 32'h0000_2233;
    step();
    st_valid = 1'b0; ld_addr = 12'h011;
    #1;
    chk("t2_hz2", 32'(o_ld_hazard), 32'd1);
    chk("t2_count2", 32'(o_sb_count), 32'd2);
    hst_en = 1'b0;
    step();
    chk("t2_hz1", 32'(o_ld_hazard), 32'd1);
    step();
    chk("t2_hz0", 32'(o_ld_hazard), 32'd0);
    ld_addr = 12'h010;
    #1;
    chk("t2_ld", o_ld_data, 32'h11BB_2233);

    // 3: fill while the drain is stalled, then release
    hst_en = 1'b1; hst_addr = 12'h800;
    st_valid = 1'b1; st_size = 2'd2;
    for (int k = 0; k < 4; k++) begin
      st_addr = 12'(12'h100 + 4*k); st_data = t3_data[k];
      step();
    end
    chk("t3_full_ready", 32'(o_st_ready), 32'd0);
    chk("t3_full_count", 32'(o_sb_count), 32'd4);
    st_addr = 12'h110; st_data = t3_data[4];
    step();
    chk("t3_held_count", 32'(o_sb_count), 32'd4);
    hst_en = 1'b0;
    step();
    chk("t3_drain1", 32'(o_sb_count), 32'd3);
    step();
    chk("t3_acc5", 32'(o_sb_count), 32'd3);
    st_valid = 1'b0;
    step(); step(); step();
    chk("t3_empty", 32'(o_sb_empty), 32'd1);
    for (int k = 0; k < 5; k++) begin
      ld_addr = 12'(12'h100 + 4*k);
      #1;
      chk("t3_ld", o_ld_data, t3_data[k]);
    end

    // 4: illegal stores pulse misalign_err for one cycle
    for (int k = 0; k < 3; k++) begin
      st_valid = 1'b1;
      st_size  = (k == 0) ? 2'd1 : (k == 1) ? 2'd2 : 2'd3;
      st_addr  = (k == 0) ? 12'h011 : (k == 1) ? 12'h012 : 12'h020;
      st_data  = 32'hDEAD_BEEF;
      step();
      st_valid = 1'b0;
      chk("t4_pulse", 32'(o_misalign_err), 32'd1);
      chk("t4_count", 32'(o_sb_count), 32'd0);
      step();
      chk("t4_pulse_end", 32'(o_misalign_err), 32'd0);
    end
    ld_addr = 12'h010;
    #1;
    chk("t4_mem", o_ld_data, 32'h11BB_2233);

    // 5: host writes stall the drain; wrap-around load
    st_valid = 1'b1; st_size = 2'd2; st_addr = 12'h000; st_data = 32'h1234_5678;
    hst_en = 1'b1; hst_addr = 12'h000; hst_data = 8'hFF;
    step();
    st_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      hst_addr = (k == 4) ? 12'hFFF : 12'(k);
      hst_data = (k == 4) ? 8'hEE : 8'hFF;
      step();
    end
    chk("t5_waiting", 32'(o_sb_count), 32'd1);
    ld_addr = 12'h000;
    #1;
    chk("t5_host_ld", o_ld_data, 32'hFFFF_FFFF);
    chk("t5_hz", 32'(o_ld_hazard), 32'd1);
    ld_addr = 12'hFFF;
    #1;
    chk("t5_hz_wrap", 32'(o_ld_hazard), 32'd1);
    hst_en = 1'b0;
    ld_addr = 12'h000;
    step();
    chk("t5_drained", 32'(o_sb_count), 32'd0);
    chk("t5_ld", o_ld_data, 32'h1234_5678);
    ld_addr = 12'hFFF;
    #1;
    chk("t5_ld_wrap", o_ld_data, 32'h3456_78EE);

    // 6: async reset discards buffered stores
    hst_en = 1'b1; hst_data = 8'h00;
    for (int a = 12'h200; a < 12'h20C; a++) begin
      hst_addr = 12'(a);
      step();
    end
    hst_addr = 12'h800;
    st_valid = 1'b1; st_size = 2'd2;
    for (int k = 0; k < 3; k++) begin
      st_addr = 12'(12'h200 + 4*k); st_data = 32'h5555_0000 + 32'(k);
      step();
    end
    st_valid = 1'b0;
    chk("t6_count3", 32'(o_sb_count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_count", 32'(o_sb_count), 32'd0);
    chk("t6_rst_empty", 32'(o_sb_empty), 32'd1);
    step(); step();
    rst_n = 1'b1; hst_en = 1'b0;
    step(); step();
    for (int k = 0; k < 3; k++) begin
      ld_addr = 12'(12'h200 + 4*k);
      #1;
      chk("t6_mem", o_ld_data, 32'h0000_0000);
    end
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_dtcm_store_buffer
`default_nettype wire

// File: doc/dtcm_store_buffer.md
Name: dtcm_store_buffer

Overview:
Next-generation data TCM for the core. It replaces the byte-only write path with a parametrised byte-addressed memory and a store buffer holding SB, SH and SW stores. The writeback stage pushes stores into the FIFO, and the FIFO drains them into memory with per-byte enables. The host loader keeps a byte write port with priority. The execute stage has a 32-bit combinational load port plus a load-hazard flag that stalls loads hitting a buffered store.

Parameters:
AW, 12, byte address width; memory is 2**AW bytes.
SB_DEPTH, 4, store buffer entries; power of two, minimum 2.

Ports:
clk  in  1  clock
rst_  in  1  reset
st_valid  in  1  writeback store request
st_ready  out  1  buffer can accept a store
st_addr  in  AW  store byte address
st_data  in  32  store data; low bytes used for SB/SH
st_size  in  2  00=SB, 01=SH, 10=SW, 11=illegal
hst_en  in  1  host loader byte write
hst_addr  in  AW  host byte address
hst_data  in  8  host byte
ld_addr  in  AW  execute load byte address
ld_data  out  32  bytes {ld_addr+3, +2, +1, +0}, little-endian
ld_hazard  out  1  load overlaps a buffered store
sb_empty  out  1  buffer empty
sb_count  out  $clog2(SB_DEPTH+1)  occupied entries
misalign_err  out  1  one-cycle pulse: store was dropped

Behaviour:
- Clock and reset: one clock, clk. Reset rst_ is asynchronous and active-low.
- Reset values:
  - wr_ptr = rd_ptr = 0, sb_count = 0.
  - sb_empty = 1, st_ready = 1, misalign_err = 0.
  - Memory contents are not reset; the host reloads them.
  - Reset mid-operation discards all buffered stores.
- Accept rule:
  - A store is accepted on a posedge with st_valid && st_ready.
  - st_ready = (sb_count < SB_DEPTH). It is derived from registered state only; there is no same-cycle drain bypass, so a full buffer deasserts st_ready even when it drains that cycle.
- Alignment check on accept:
  - Illegal if st_size==11, or SH with addr[0]!=0, or SW with addr[1:0]!=0.
  - An illegal store is consumed but not enqueued.
  - misalign_err = 1 for exactly the next cycle.
- Entry format: {word_addr[AW-3:0], be[3:0], data[31:0]}. Data is lane-shifted at enqueue time:
  - SB: be = 1 << addr[1:0].
  - SH: be = 0011 << addr[1:0].
  - SW: be = 1111.
- Drain:
  - Each posedge with !sb_empty && !hst_en, the head entry writes its enabled byte lanes and rd_ptr advances.
  - hst_en stalls the drain; the host byte is written that edge instead.
  - Drain starvation under continuous hst_en is allowed.
- Pointers wrap modulo SB_DEPTH.
  - Simultaneous accept and drain: sb_count unchanged.
  - Accept while empty: the entry drains at the next edge at the earliest. Minimum store-to-visible latency is 2 posedges.
- Loads:
  - ld_data is combinational from memory. Byte addresses wrap modulo 2**AW, so 0xFFF returns {mem[2], mem[1], mem[0], mem[FFF]}.
  - No forwarding from the buffer.
- ld_hazard = 1 if any occupied entry's word_addr equals ld_addr[AW-1:2] or (ld_addr+3)[AW-1:2], modulo wrap.
  - The comparison ignores byte enables, which is conservative.
  - Execute must hold the load while ld_hazard is high.
- Host writes during operation are legal. Ordering against buffered stores to the same byte is the host's responsibility; the host writes only while the core is held in start=0.

Decomposition:
- Shared package / cpu_define additions:
  - store size codes SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10.
  - entry field widths.
  - byte-enable patterns BE_B = 4'b0001, BE_H = 4'b0011, BE_W = 4'b1111.
- Sub-module dtcm_sb_fifo: a circular FIFO (SB_DEPTH, entry width) exposing push/pop, count, and a flattened valid+word_addr vector for the hazard comparators.
- Top-level dtcm_store_buffer holds the following:
  - alignment check and lane shifting
  - memory array with byte-enable writes
  - host/drain arbitration
  - load mux and hazard logic

Test Plan:
1. Reset with st_valid=1 -> all reset values hold while rst_=0. After release, SW addr 0x010 data 0xAABBCCDD -> sb_count=1, then 0; ld_addr=0x010 returns 0xAABBCCDD two edges after accept.
2. SB 0x013 data 0x11, then SH 0x010 data 0x2233 over mem word 0 -> after drain, ld 0x010 = 0x11BB2233. ld_hazard=1 for ld 0x011 while either entry is buffered.
3. Five back-to-back SW with hst_en=1 (drain stalled, SB_DEPTH=4) -> st_ready=0 after the 4th accept, 5th held. Drop hst_en -> 5th accepted one edge after the first drain. Final memory order is correct and pointers wrap.
4. SH at 0x011, SW at 0x012, st_size=11 -> each gives a misalign_err pulse of exactly 1 cycle, sb_count stays 0, memory unchanged.
5. Host writes 0xFF to 0x000..0x003 while an SW 0x000 data 0x12345678 is buffered -> drain waits for hst_en low, then the word reads 0x12345678. ld 0xFFF returns bytes wrapped across 0xFFF/0x000.
6. Assert rst_ low asynchronously (mid-cycle) with 3 entries buffered -> sb_count=0 and sb_empty=1 immediately. Those stores never reach memory.
